// File: rtl/key_buffer.sv
// key_buffer: PS/2 key FIFO with a memory-mapped read port and a
// level interrupt request. Each new key press (rising edge of key_pressed
// with a non-zero character) is queued; the CPU pops entries by reading
// KEY_ADDR and inspects occupancy/overflow by reading STAT_ADDR.
module key_buffer #(
    parameter int          DEPTH     = 16,
    parameter logic [63:0] KEY_ADDR  = 64'h0000_0000_0000_3400,
    parameter logic [63:0] STAT_ADDR = KEY_ADDR + 64'd8
) (
    input  logic                     CLOCK_50,
    input  logic                     KEY0,
    input  logic [7:0]               ascii,
    input  logic                     key_pressed,
    input  logic [63:0]              bus_address,
    input  logic                     bus_read_enable,
    output logic [63:0]              bus_read_data,
    output logic                     bus_read_done,
    output logic [3:0]               interrupt_vector,
    input  logic                     interrupt_ack,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    // Number of count bits that fit into the 8-bit status count field.
    localparam int SW = (CW < 8) ? CW : 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        ACKW = 2'd2
    } irq_state_t;

    // Status word: overflow at bit 8, occupancy in the low byte.
    function automatic logic [63:0] status_word(input logic ovf, input logic [SW-1:0] cnt);
        logic [63:0] w;
        w         = 64'd0;
        w[8]      = ovf;
        w[SW-1:0] = cnt;
        return w;
    endfunction

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_next_s;
    logic          overflow_r;
    logic          overflow_next_s;
    logic          key_pressed_q_r;
    logic          strobe_q_r;
    logic [63:0]   read_data_r;
    logic [63:0]   read_data_next_s;
    logic          read_done_r;
    logic          read_done_next_s;
    irq_state_t    state_r;
    irq_state_t    state_next_s;
    logic [3:0]    vector_s;

    logic push_req_s;
    logic key_hit_s;
    logic stat_hit_s;
    logic strobe_s;
    logic start_s;
    logic key_start_s;
    logic stat_start_s;
    logic full_s;
    logic empty_s;
    logic pop_s;
    logic push_s;
    logic drop_s;

    // Event decode: key edge, bus transaction start, push/pop/drop qualifiers.
    always_comb begin
        push_req_s   = key_pressed & ~key_pressed_q_r & (ascii != 8'd0);
        key_hit_s    = (bus_address == KEY_ADDR);
        stat_hit_s   = (bus_address == STAT_ADDR);
        strobe_s     = bus_read_enable & (key_hit_s | stat_hit_s);
        start_s      = strobe_s & ~strobe_q_r;
        key_start_s  = start_s & key_hit_s;
        stat_start_s = start_s & stat_hit_s & ~key_hit_s;
        full_s       = (count_r == CW'(DEPTH));
        empty_s      = (count_r == CW'(0));
        pop_s        = key_start_s & ~empty_s;
        // A full FIFO may still accept a key when the same cycle frees a slot.
        push_s       = push_req_s & (~full_s | pop_s);
        drop_s       = push_req_s & full_s & ~pop_s;
    end

    // Next occupancy from the push/pop pair; a simultaneous push and pop cancel.
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CW'(1);
            2'b01:   count_next_s = count_r - CW'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Sticky overflow: a drop wins over a status-read clear in the same cycle.
    always_comb begin
        overflow_next_s = overflow_r;
        if (drop_s) begin
            overflow_next_s = 1'b1;
        end else if (stat_start_s) begin
            overflow_next_s = 1'b0;
        end else begin
            overflow_next_s = overflow_r;
        end
    end

    // Read data is latched only at a transaction start and held otherwise.
    always_comb begin
        read_data_next_s = read_data_r;
        if (key_start_s) begin
            if (empty_s) begin
                read_data_next_s = 64'd0;
            end else begin
                read_data_next_s = {56'd0, mem_r[rd_ptr_r]};
            end
        end else if (stat_start_s) begin
            read_data_next_s = status_word(overflow_r, count_r[SW-1:0]);
        end else begin
            read_data_next_s = read_data_r;
        end
        // Done follows the strobe from the cycle after the start until release.
        read_done_next_s = start_s | (read_done_r & bus_read_enable);
    end

    // FIFO storage; contents are don't-care after reset, so no reset here.
    always_ff @(posedge CLOCK_50) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= ascii;
        end
    end

    // FIFO control, edge-detect registers and bus response registers.
    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            wr_ptr_r        <= '0;
            rd_ptr_r        <= '0;
            count_r         <= '0;
            overflow_r      <= 1'b0;
            key_pressed_q_r <= 1'b0;
            strobe_q_r      <= 1'b0;
            read_data_r     <= 64'd0;
            read_done_r     <= 1'b0;
        end else begin
            key_pressed_q_r <= key_pressed;
            strobe_q_r      <= strobe_s;
            count_r         <= count_next_s;
            overflow_r      <= overflow_next_s;
            read_data_r     <= read_data_next_s;
            read_done_r     <= read_done_next_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
        end
    end

    // Interrupt FSM state register.
    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Interrupt FSM next state: only an ack withdraws a pending request.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (!empty_s) begin
                    state_next_s = PEND;
                end else begin
                    state_next_s = IDLE;
                end
            end
            PEND: begin
                if (interrupt_ack) begin
                    state_next_s = ACKW;
                end else begin
                    state_next_s = PEND;
                end
            end
            ACKW: begin
                if (!interrupt_ack) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = ACKW;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Interrupt FSM output decode: request code only while pending.
    always_comb begin
        vector_s = 4'd0;
        case (state_r)
            PEND:    vector_s = 4'd1;
            default: vector_s = 4'd0;
        endcase
    end

    assign bus_read_data    = read_data_r;
    assign bus_read_done    = read_done_r;
    assign interrupt_vector = vector_s;
    assign count            = count_r;
    assign overflow         = overflow_r;

endmodule

// File: tb/tb_key_buffer.sv
// Directed testbench for key_buffer (DEPTH = 16) with hand-computed expectations.
module tb_key_buffer;

    localparam logic [63:0] KEY_ADDR  = 64'h0000_0000_0000_3400;
    localparam logic [63:0] STAT_ADDR = 64'h0000_0000_0000_3408;

    logic        clk;
    logic        key0;
    logic [7:0]  ascii;
    logic        key_pressed;
    logic [63:0] bus_address;
    logic        bus_read_enable;
    logic [63:0] bus_read_data;
    logic        bus_read_done;
    logic [3:0]  interrupt_vector;
    logic        interrupt_ack;
    logic [4:0]  count;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    key_buffer dut (
        .CLOCK_50         (clk),
        .KEY0             (key0),
        .ascii            (ascii),
        .key_pressed      (key_pressed),
        .bus_address      (bus_address),
        .bus_read_enable  (bus_read_enable),
        .bus_read_data    (bus_read_data),
        .bus_read_done    (bus_read_done),
        .interrupt_vector (interrupt_vector),
        .interrupt_ack    (interrupt_ack),
        .count            (count),
        .overflow         (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [7:0] ch);
        ascii       = ch;
        key_pressed = 1'b1;
        tick(1);
        key_pressed = 1'b0;
        ascii       = 8'd0;
        tick(1);
    endtask

    task automatic bus_read(input logic [63:0] addr, output logic [63:0] data);
        bus_address     = addr;
        bus_read_enable = 1'b1;
        tick(1);
        check_eq("done_high", 64'(bus_read_done), 64'd1);
        data            = bus_read_data;
        bus_read_enable = 1'b0;
        tick(1);
        check_eq("done_low", 64'(bus_read_done), 64'd0);
    endtask

    initial begin
        logic [63:0] d;
        logic        held_ok;

        key0            = 1'b0;
        ascii           = 8'd0;
        key_pressed     = 1'b0;
        bus_address     = 64'd0;
        bus_read_enable = 1'b0;
        interrupt_ack   = 1'b0;
        tick(2);
        check_eq("rst_data", bus_read_data, 64'd0);
        check_eq("rst_done", 64'(bus_read_done), 64'd0);
        check_eq("rst_vec", 64'(interrupt_vector), 64'd0);
        check_eq("rst_count", 64'(count), 64'd0);
        check_eq("rst_ovf", 64'(overflow), 64'd0);
        key0 = 1'b1;
        tick(1);

        // Push sequence a, b, c then drain past empty.
        press(8'h61);
        press(8'h62);
        press(8'h63);
        check_eq("push3_count", 64'(count), 64'd3);
        check_eq("push3_vec", 64'(interrupt_vector), 64'd1);
        bus_read(KEY_ADDR, d); check_eq("pop_a", d, 64'h61);
        bus_read(KEY_ADDR, d); check_eq("pop_b", d, 64'h62);
        bus_read(KEY_ADDR, d); check_eq("pop_c", d, 64'h63);
        bus_read(KEY_ADDR, d); check_eq("pop_empty", d, 64'd0);
        check_eq("drain_count", 64'(count), 64'd0);
        check_eq("drained_vec_kept", 64'(interrupt_vector), 64'd1);
        interrupt_ack = 1'b1;
        tick(1);
        check_eq("ack_vec0", 64'(interrupt_vector), 64'd0);
        interrupt_ack = 1'b0;
        tick(2);
        check_eq("idle_vec0", 64'(interrupt_vector), 64'd0);

        // Held strobe: one pop for a 1000-cycle read.
        press(8'h78);
        press(8'h79);
        bus_address     = KEY_ADDR;
        bus_read_enable = 1'b1;
        tick(1);
        check_eq("held_data", bus_read_data, 64'h78);
        held_ok = 1'b1;
        for (int i = 0; i < 999; i++) begin
            if (bus_read_done !== 1'b1) held_ok = 1'b0;
            tick(1);
        end
        check_eq("held_done", 64'(held_ok), 64'd1);
        check_eq("held_count", 64'(count), 64'd1);
        bus_read_enable = 1'b0;
        tick(1);
        check_eq("held_release", 64'(bus_read_done), 64'd0);

        // Other address: no response.
        bus_address     = KEY_ADDR + 64'd16;
        bus_read_enable = 1'b1;
        tick(3);
        check_eq("miss_done", 64'(bus_read_done), 64'd0);
        check_eq("miss_count", 64'(count), 64'd1);
        check_eq("miss_data", bus_read_data, 64'h78);
        bus_read_enable = 1'b0;
        tick(1);

        // Interrupt handshake with 2 entries.
        press(8'h7A);
        check_eq("hs_count", 64'(count), 64'd2);
        check_eq("hs_vec1", 64'(interrupt_vector), 64'd1);
        interrupt_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check_eq("hs_hold_vec0", 64'(interrupt_vector), 64'd0);
        end
        interrupt_ack = 1'b0;
        tick(1);
        check_eq("hs_rel1_vec0", 64'(interrupt_vector), 64'd0);
        tick(1);
        check_eq("hs_rel2_vec1", 64'(interrupt_vector), 64'd1);
        bus_read(KEY_ADDR, d); check_eq("pop_y", d, 64'h79);
        bus_read(KEY_ADDR, d); check_eq("pop_z", d, 64'h7A);
        interrupt_ack = 1'b1;
        tick(1);
        interrupt_ack = 1'b0;
        tick(2);
        interrupt_ack = 1'b1;
        tick(5);
        check_eq("empty_hold_vec0", 64'(interrupt_vector), 64'd0);
        interrupt_ack = 1'b0;
        tick(2);
        check_eq("empty_rel_vec0", 64'(interrupt_vector), 64'd0);

        // Overflow and pointer wrap.
        for (int i = 0; i < 17; i++) press(8'h41 + 8'(i));
        check_eq("ovf_count", 64'(count), 64'd16);
        check_eq("ovf_flag", 64'(overflow), 64'd1);
        bus_read(STAT_ADDR, d); check_eq("stat1", d, 64'h110);
        check_eq("ovf_cleared", 64'(overflow), 64'd0);
        bus_read(STAT_ADDR, d); check_eq("stat2", d, 64'h010);
        for (int i = 0; i < 16; i++) begin
            bus_read(KEY_ADDR, d);
            check_eq("wrap_drain", d, 64'(8'h41 + 8'(i)));
        end
        check_eq("wrap_count", 64'(count), 64'd0);

        // Collision: push and pop in the same cycle on a full FIFO.
        for (int i = 0; i < 16; i++) press(8'h30 + 8'(i));
        ascii           = 8'h7A;
        key_pressed     = 1'b1;
        bus_address     = KEY_ADDR;
        bus_read_enable = 1'b1;
        tick(1);
        check_eq("coll_data", bus_read_data, 64'h30);
        check_eq("coll_count", 64'(count), 64'd16);
        check_eq("coll_ovf", 64'(overflow), 64'd0);
        key_pressed     = 1'b0;
        ascii           = 8'd0;
        bus_read_enable = 1'b0;
        tick(1);
        for (int i = 0; i < 15; i++) begin
            bus_read(KEY_ADDR, d);
            check_eq("coll_drain", d, 64'(8'h31 + 8'(i)));
        end
        bus_read(KEY_ADDR, d); check_eq("coll_last", d, 64'h7A);
        check_eq("coll_empty", 64'(count), 64'd0);

        // Overflow set coinciding with a status-read clear.
        for (int i = 0; i < 16; i++) press(8'h50 + 8'(i));
        ascii           = 8'h55;
        key_pressed     = 1'b1;
        bus_address     = STAT_ADDR;
        bus_read_enable = 1'b1;
        tick(1);
        check_eq("setclr_data", bus_read_data, 64'h010);
        check_eq("setclr_ovf", 64'(overflow), 64'd1);
        check_eq("setclr_count", 64'(count), 64'd16);
        key_pressed     = 1'b0;
        ascii           = 8'd0;
        bus_read_enable = 1'b0;
        tick(1);

        // Reset clears the queue and overflow.
        key0 = 1'b0;
        tick(1);
        key0 = 1'b1;
        tick(1);
        check_eq("rst2_count", 64'(count), 64'd0);
        check_eq("rst2_ovf", 64'(overflow), 64'd0);

        // Asynchronous reset mid-transaction with 5 entries left.
        for (int i = 0; i < 6; i++) press(8'h21 + 8'(i));
        bus_address     = KEY_ADDR;
        bus_read_enable = 1'b1;
        tick(1);
        check_eq("pre_rst_done", 64'(bus_read_done), 64'd1);
        check_eq("pre_rst_count", 64'(count), 64'd5);
        check_eq("pre_rst_data", bus_read_data, 64'h21);
        key0 = 1'b0;
        #2;
        check_eq("arst_data", bus_read_data, 64'd0);
        check_eq("arst_done", 64'(bus_read_done), 64'd0);
        check_eq("arst_vec", 64'(interrupt_vector), 64'd0);
        check_eq("arst_count", 64'(count), 64'd0);
        check_eq("arst_ovf", 64'(overflow), 64'd0);
        bus_read_enable = 1'b0;
        tick(2);
        key0 = 1'b1;
        tick(2);
        check_eq("post_rst_count", 64'(count), 64'd0);
        check_eq("post_rst_done", 64'(bus_read_done), 64'd0);
        check_eq("post_rst_vec", 64'(interrupt_vector), 64'd0);
        bus_read(KEY_ADDR, d); check_eq("post_rst_read", d, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_buffer.md
KEY_BUFFER -- requirements
Module: key_buffer

Interface
- REQ-001: Parameter DEPTH, default 16, FIFO entries; power of two, 2..256.
- REQ-002: Parameter KEY_ADDR, default 64'h0000_0000_0000_3400, data/pop address.
- REQ-003: Parameter STAT_ADDR, default KEY_ADDR+8, status address.
- REQ-004: CLOCK_50  in  1  system clock; all state on rising edge.
- REQ-005: KEY0  in  1  reset, asynchronous, active-low.
- REQ-006: ascii  in  8  decoded character from the PS/2 decoder; valid while key_pressed high.
- REQ-007: key_pressed  in  1  decoder level, high while a key is held.
- REQ-008: bus_address  in  64  CPU bus address.
- REQ-009: bus_read_enable  in  1  CPU read strobe; may stay high for many CLOCK_50 cycles.
- REQ-010: bus_read_data  out  64  read result, zero-extended.
- REQ-011: bus_read_done  out  1  read data valid.
- REQ-012: interrupt_vector  out  4  interrupt request code to the CPU; 0 = none.
- REQ-013: interrupt_ack  in  1  CPU acknowledge, level.
- REQ-014: count  out  $clog2(DEPTH)+1  current occupancy.
- REQ-015: overflow  out  1  sticky, set when a key is dropped.

Function
- REQ-016: The block SHALL register key_pressed once per cycle; push_req = key_pressed & ~key_pressed_q & (ascii != 0).
- REQ-017: The block SHALL write ascii at the write pointer on a push_req cycle when not full, or when full and a pop occurs in the same cycle; the new count is visible the next cycle.
- REQ-018: A push_req while full with no simultaneous pop SHALL drop the character, set overflow, and leave the pointers unchanged.
- REQ-019: Pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0; full = (count==DEPTH); empty = (count==0).
- REQ-020: A read transaction SHALL start on the rising edge of (bus_read_enable & address hit), detected against a registered copy of that qualified strobe.
- REQ-021: On a transaction start at KEY_ADDR, the block SHALL latch {56'd0, head entry} into bus_read_data and pop one entry when non-empty, or latch 64'd0 with no pop when empty.
- REQ-022: On a transaction start at STAT_ADDR, the block SHALL latch {overflow at bit 8, count in bits 7:0, all other bits 0} and clear overflow in the same cycle.
- REQ-023: A set of overflow coinciding with a status-read clear SHALL leave overflow = 1.
- REQ-024: Exactly one pop SHALL occur per transaction, regardless of how long bus_read_enable is held.
- REQ-025: bus_read_done SHALL rise the cycle after the transaction start, hold while bus_read_enable is high, and fall the cycle after bus_read_enable falls.
- REQ-026: bus_read_data SHALL hold its latched value until the next transaction start.
- REQ-027: A simultaneous push and pop SHALL leave count unchanged and keep FIFO order.
- REQ-028: Reads at any other address SHALL produce no response: done, data and FIFO unchanged.
- REQ-029: The interrupt FSM SHALL have states IDLE, PEND and ACKW.
- REQ-030: IDLE -> PEND when count != 0; interrupt_vector = 4'd1 only in PEND.
- REQ-031: PEND -> ACKW when interrupt_ack = 1; vector = 0 from the next cycle.
- REQ-032: ACKW -> IDLE when interrupt_ack = 0; if the FIFO is still non-empty, the FSM re-enters PEND on the following cycle.
- REQ-033: A FIFO drained by reads while in PEND SHALL NOT withdraw the request; only an ack clears it.

Reset
- REQ-034: While KEY0 = 0, the block SHALL clear pointers, count, overflow, key_pressed_q, the strobe register, bus_read_data (64'd0) and bus_read_done (0), set interrupt_vector = 0, and put the FSM in IDLE.
- REQ-035: A reset asserted mid-transaction or mid-interrupt SHALL discard all queued keys; after release the block SHALL respond only to new edges.
- REQ-036: FIFO storage contents need not be reset.

Verification
- REQ-037: Push sequence: press 'a' (8'h61), 'b', 'c' as separate key_pressed pulses -> count = 3, interrupt_vector = 1; three KEY_ADDR reads return 0x61, 0x62, 0x63; a fourth returns 0 with count = 0.
- REQ-038: Held strobe: bus_read_enable held 1000 cycles at KEY_ADDR with 2 entries queued -> one pop, count = 1, done high for the full hold, low one cycle after release.
- REQ-039: Overflow and wrap: 17 presses with DEPTH = 16 -> count = 16; status read returns 0x110, then a second status read returns 0x010; draining yields the first 16 characters in order.
- REQ-040: Collision: push_req in the same cycle as a pop on a full FIFO -> count stays 16, overflow stays 0, new char is read last.
- REQ-041: Interrupt handshake: ack held 5 cycles with 2 entries -> vector 0 during the hold, returns to 1 two cycles after ack falls; repeat with an empty FIFO -> stays 0.
- REQ-042: Reset: KEY0 pulsed low while done = 1 and count = 5 -> all outputs 0 asynchronously, count = 0 after release.
